// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT encoder/decoder blocks.
package bwt_pkg;

  localparam int SYM_W = 8;
  localparam int ALPHA = 256;

  // Sequencer-phase state encodings shared by the BWT blocks.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_COUNT  = 3'd2,
    ST_PREFIX = 3'd3,
    ST_DECODE = 3'd4,
    ST_DONE   = 3'd5
  } bwt_state_e;

endpackage

// File: rtl/ibwt_sym_table.sv
// Per-symbol count table: ALPHA entries, combinational read, synchronous write.
module ibwt_sym_table
  import bwt_pkg::*;
#(
  parameter int LEN_ADDR = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [SYM_W-1:0]    waddr,
  input  logic [LEN_ADDR-1:0] wdata,
  input  logic [SYM_W-1:0]    raddr,
  output logic [LEN_ADDR-1:0] rdata
);

  logic [LEN_ADDR-1:0] mem [ALPHA];

  // Contents are defined by the CLEAR pass, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ibwt_decoder.sv
// Inverse BWT: count symbols, prefix-sum, then walk the LF mapping backwards
// writing S[n-1]..S[0] to OUT_BASE+k.
module ibwt_decoder
  import bwt_pkg::*;
#(
  parameter int                  LEN_ADDR = 10,
  parameter logic [LEN_ADDR-1:0] OUT_BASE = LEN_ADDR'(512)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                CS,
  input  logic [LEN_ADDR-1:0] len_str,
  input  logic [LEN_ADDR-1:0] pidx,
  input  logic [SYM_W-1:0]    din,
  output logic                ren,
  output logic                wen,
  output logic [LEN_ADDR-1:0] addr,
  output logic [LEN_ADDR-1:0] addr1,
  output logic [SYM_W-1:0]    dout,
  output logic                flag,
  output logic                err
);

  localparam logic [LEN_ADDR-1:0] LAST_SYM = LEN_ADDR'(ALPHA - 1);
  localparam logic [LEN_ADDR-1:0] ONE      = LEN_ADDR'(1);

  bwt_state_e          state, state_nxt;
  logic [LEN_ADDR-1:0] n_q, pidx_q, idx, j_q, k_q, sum_q;
  logic                ph_q, err_q;
  logic                active;

  logic                tbl_we;
  logic [SYM_W-1:0]    tbl_waddr, tbl_raddr;
  logic [LEN_ADDR-1:0] tbl_wdata, tbl_rdata;

  logic [LEN_ADDR-1:0] rank_mem [2**LEN_ADDR];
  logic                rank_we;
  logic [LEN_ADDR-1:0] rank_waddr, rank_wdata, rank_rd;

  assign active = CS & ~reset;

  ibwt_sym_table #(.LEN_ADDR(LEN_ADDR)) u_ctab (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (tbl_raddr),
    .rdata (tbl_rdata)
  );

  // rank[i] = occurrences of L[i] before position i.
  always_ff @(posedge clk) begin
    if (rank_we) rank_mem[rank_waddr] <= rank_wdata;
  end

  assign rank_rd = rank_mem[j_q];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: every busy state aborts to IDLE when CS drops.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (CS) state_nxt = (len_str == '0 || pidx >= len_str) ? ST_DONE : ST_CLEAR;
      ST_CLEAR:  if (!CS) state_nxt = ST_IDLE; else if (idx == LAST_SYM) state_nxt = ST_COUNT;
      ST_COUNT:  if (!CS) state_nxt = ST_IDLE; else if (idx == n_q) state_nxt = ST_PREFIX;
      ST_PREFIX: if (!CS) state_nxt = ST_IDLE; else if (idx == LAST_SYM) state_nxt = ST_DECODE;
      ST_DECODE: if (!CS) state_nxt = ST_IDLE; else if (ph_q && k_q == '0) state_nxt = ST_DONE;
      ST_DONE:   if (!CS) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Table/rank control and memory port outputs. The count table write lands
  // at the edge, before the next cycle's combinational read, so repeated
  // symbols in COUNT see the updated count without a stall.
  always_comb begin
    tbl_we     = 1'b0;
    tbl_waddr  = '0;
    tbl_wdata  = '0;
    tbl_raddr  = '0;
    rank_we    = 1'b0;
    rank_waddr = '0;
    rank_wdata = '0;
    ren        = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    addr1      = '0;
    dout       = '0;
    case (state)
      ST_CLEAR: begin
        tbl_we    = 1'b1;
        tbl_waddr = idx[SYM_W-1:0];
      end
      ST_COUNT: begin
        // din carries L[idx-1] from the read issued last cycle.
        if (idx != '0) begin
          tbl_raddr  = din;
          tbl_we     = 1'b1;
          tbl_waddr  = din;
          tbl_wdata  = tbl_rdata + ONE;
          rank_we    = 1'b1;
          rank_waddr = idx - ONE;
          rank_wdata = tbl_rdata;
        end
        if (idx < n_q) begin
          ren  = 1'b1;
          addr = idx;
        end
      end
      ST_PREFIX: begin
        tbl_raddr = idx[SYM_W-1:0];
        tbl_we    = 1'b1;
        tbl_waddr = idx[SYM_W-1:0];
        tbl_wdata = sum_q;
      end
      ST_DECODE: begin
        if (!ph_q) begin
          ren  = 1'b1;
          addr = j_q;
        end else begin
          tbl_raddr = din;
          wen       = 1'b1;
          addr1     = OUT_BASE + k_q;
          dout      = din;
        end
      end
      default: ;
    endcase
    if (!active) begin
      tbl_we  = 1'b0;
      rank_we = 1'b0;
      ren     = 1'b0;
      wen     = 1'b0;
      addr    = '0;
      addr1   = '0;
      dout    = '0;
    end
  end

  // Loop counters, running prefix sum and LF walk registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q    <= '0;
      pidx_q <= '0;
      idx    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      sum_q  <= '0;
      ph_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (CS) begin
          n_q    <= len_str;
          pidx_q <= pidx;
          err_q  <= (len_str != '0) && (pidx >= len_str);
          idx    <= '0;
        end
        ST_CLEAR:  idx <= (idx == LAST_SYM) ? '0 : idx + ONE;
        ST_COUNT: begin
          idx   <= (idx == n_q) ? '0 : idx + ONE;
          sum_q <= '0;
        end
        ST_PREFIX: begin
          sum_q <= sum_q + tbl_rdata;
          idx   <= idx + ONE;
          j_q   <= pidx_q;
          k_q   <= n_q - ONE;
          ph_q  <= 1'b0;
        end
        ST_DECODE: begin
          ph_q <= ~ph_q;
          if (ph_q) begin
            j_q <= tbl_rdata + rank_rd;
            k_q <= k_q - ONE;
          end
        end
        ST_DONE: if (!CS) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign flag = (state == ST_DONE) & ~reset;
  assign err  = flag & err_q;

endmodule
